// File: rtl/mmio_periph_pkg.sv
// Register map, status bit positions and reset constants for the mmio_periph block.
package mmio_periph_pkg;

    localparam logic [15:0] OFF_SCROLL    = 16'h0000;
    localparam logic [15:0] OFF_CURSOR    = 16'h0004;
    localparam logic [15:0] OFF_KB_STATUS = 16'h0008;
    localparam logic [15:0] OFF_KB_DATA   = 16'h000C;
    localparam logic [15:0] OFF_KB_CTRL   = 16'h0010;
    localparam logic [15:0] OFF_TIMER     = 16'h0014;
    localparam logic [15:0] OFF_LEDR      = 16'h0018;
    localparam logic [15:0] OFF_HEX_BASE  = 16'h0020;

    localparam int ST_NEMPTY  = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_OVF_CLR = 1;

    localparam logic [6:0] HEX_BLANK = 7'h7F;

endpackage

// File: rtl/mmio_periph_kb_fifo.sv
// Keyboard scancode FIFO: circular buffer with wrapping pointers and an explicit count.
module kb_fifo #(
    parameter int KB_DEPTH = 16,
    parameter int KB_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic                          i_flush,
    input  logic [KB_W-1:0]               i_data,
    output logic [KB_W-1:0]               o_head,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [$clog2(KB_DEPTH):0]     o_count
);

    localparam int AW = $clog2(KB_DEPTH);

    logic [KB_W-1:0] r_mem [KB_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(KB_DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !i_flush && w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/mmio_periph.sv
// Memory-mapped peripheral register block: VGA scroll/cursor, 7-seg, LEDs, cycle timer, keyboard FIFO.
module mmio_periph
    import mmio_periph_pkg::*;
#(
    parameter int NUM_HEX  = 6,
    parameter int LED_W    = 10,
    parameter int KB_DEPTH = 16,
    parameter int KB_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cpu_sel,
    input  logic [15:0]            cpu_addr,
    input  logic                   cpu_we,
    input  logic                   cpu_re,
    input  logic [31:0]            cpu_wrdata,
    output logic [31:0]            cpu_rddata,
    input  logic                   kb_valid,
    input  logic [KB_W-1:0]        kb_data,
    output logic [31:0]            vga_extra_line_cnt,
    output logic [15:0]            vga_cursor_x,
    output logic [15:0]            vga_cursor_y,
    output logic [7*NUM_HEX-1:0]   hex,
    output logic [LED_W-1:0]       ledr
);

    localparam int AW = $clog2(KB_DEPTH);

    logic [31:0]              r_scroll;
    logic [15:0]              r_cur_x;
    logic [15:0]              r_cur_y;
    logic [31:0]              r_timer;
    logic [LED_W-1:0]         r_ledr;
    logic [NUM_HEX-1:0][6:0]  r_hex;
    logic                     r_ovf;
    logic [31:0]              r_rddata;

    logic [15:0]      w_off;
    logic             w_wr;
    logic             w_rd;
    logic             w_hex_hit;
    logic             w_pop;
    logic             w_flush;
    logic             w_ovf_clr;
    logic             w_ovf_evt;
    logic [31:0]      w_rdval;
    logic [KB_W-1:0]  w_head;
    logic             w_empty;
    logic             w_full;
    logic [AW:0]      w_count;
    logic             w_unused;

    assign w_unused  = ^cpu_addr[1:0];
    assign w_off     = {cpu_addr[15:2], 2'b00};
    assign w_wr      = cpu_sel && cpu_we;
    // A simultaneous write wins; the read side then neither pops nor returns data.
    assign w_rd      = cpu_sel && cpu_re && !cpu_we;
    assign w_hex_hit = (w_off[15:5] == OFF_HEX_BASE[15:5]) && (int'(w_off[4:2]) < NUM_HEX);

    assign w_pop     = w_rd && (w_off == OFF_KB_DATA);
    assign w_flush   = w_wr && (w_off == OFF_KB_CTRL) && cpu_wrdata[CTRL_FLUSH];
    assign w_ovf_clr = w_wr && (w_off == OFF_KB_CTRL) && cpu_wrdata[CTRL_OVF_CLR];
    assign w_ovf_evt = kb_valid && w_full && !w_pop && !w_flush;

    kb_fifo #(
        .KB_DEPTH (KB_DEPTH),
        .KB_W     (KB_W)
    ) u_kb_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (kb_valid),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (kb_data),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    always_comb begin
        w_rdval = '0;
        case (w_off)
            OFF_SCROLL:    w_rdval = r_scroll;
            OFF_CURSOR:    w_rdval = {r_cur_y, r_cur_x};
            OFF_KB_STATUS: begin
                w_rdval[ST_NEMPTY]            = !w_empty;
                w_rdval[ST_FULL]              = w_full;
                w_rdval[ST_OVF]               = r_ovf;
                w_rdval[ST_CNT_LSB +: 8]      = 8'(w_count);
            end
            OFF_KB_DATA:   w_rdval[KB_W-1:0] = w_empty ? '0 : w_head;
            OFF_TIMER:     w_rdval = r_timer;
            OFF_LEDR:      w_rdval[LED_W-1:0] = r_ledr;
            default:       w_rdval = '0;
        endcase
        for (int i = 0; i < NUM_HEX; i++) begin
            if (w_hex_hit && (w_off[4:2] == 3'(i))) w_rdval[6:0] = r_hex[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rddata <= '0;
        end else if (cpu_re) begin
            r_rddata <= w_rd ? w_rdval : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scroll <= '0;
            r_cur_x  <= '0;
            r_cur_y  <= '0;
            r_ledr   <= '0;
            r_hex    <= {NUM_HEX{HEX_BLANK}};
        end else if (w_wr) begin
            case (w_off)
                OFF_SCROLL: r_scroll <= cpu_wrdata;
                OFF_CURSOR: {r_cur_y, r_cur_x} <= cpu_wrdata;
                OFF_LEDR:   r_ledr <= cpu_wrdata[LED_W-1:0];
                default:    ;
            endcase
            for (int i = 0; i < NUM_HEX; i++) begin
                if (w_hex_hit && (w_off[4:2] == 3'(i))) r_hex[i] <= cpu_wrdata[6:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                            r_timer <= '0;
        else if (w_wr && w_off == OFF_TIMER)   r_timer <= cpu_wrdata;
        else                                   r_timer <= r_timer + 32'd1;
    end

    // Set wins over clear so an overflow coinciding with a clear is not lost.
    always_ff @(posedge clk) begin
        if (!rst_n)         r_ovf <= 1'b0;
        else if (w_ovf_evt) r_ovf <= 1'b1;
        else if (w_ovf_clr) r_ovf <= 1'b0;
    end

    assign cpu_rddata         = r_rddata;
    assign vga_extra_line_cnt = r_scroll;
    assign vga_cursor_x       = r_cur_x;
    assign vga_cursor_y       = r_cur_y;
    assign hex                = r_hex;
    assign ledr               = r_ledr;

endmodule

// File: tb/tb_mmio_periph.sv
// Randomized bench for mmio_periph against a queue-based transaction model of the register map.
module tb_mmio_periph;

    localparam int NH = 6;
    localparam int LW = 10;
    localparam int KD = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_sel = 1'b0;
    logic [15:0]   cpu_addr = '0;
    logic          cpu_we = 1'b0;
    logic          cpu_re = 1'b0;
    logic [31:0]   cpu_wrdata = '0;
    logic [31:0]   cpu_rddata;
    logic          kb_valid = 1'b0;
    logic [7:0]    kb_data = '0;
    logic [31:0]   vga_extra_line_cnt;
    logic [15:0]   vga_cursor_x;
    logic [15:0]   vga_cursor_y;
    logic [7*NH-1:0] hex;
    logic [LW-1:0] ledr;

    always #5 clk = ~clk;

    mmio_periph #(.NUM_HEX(NH), .LED_W(LW), .KB_DEPTH(KD), .KB_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr),
        .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_wrdata(cpu_wrdata), .cpu_rddata(cpu_rddata),
        .kb_valid(kb_valid), .kb_data(kb_data), .vga_extra_line_cnt(vga_extra_line_cnt),
        .vga_cursor_x(vga_cursor_x), .vga_cursor_y(vga_cursor_y), .hex(hex), .ledr(ledr)
    );

    int n_pass = 0;
    int n_tot  = 0;

    logic [7:0]    m_q[$];
    bit            m_ovf;
    logic [31:0]   m_scroll, m_cursor, m_timer, m_rd;
    logic [LW-1:0] m_led;
    logic [6:0]    m_hex[NH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] m_read(input logic [15:0] a);
        logic [15:0] o;
        logic [31:0] v;
        o = {a[15:2], 2'b00};
        v = '0;
        case (o)
            16'h00: v = m_scroll;
            16'h04: v = m_cursor;
            16'h08: begin
                v[15:8] = 8'(m_q.size());
                v[2]    = m_ovf;
                v[1]    = (m_q.size() == KD);
                v[0]    = (m_q.size() != 0);
            end
            16'h0C: v = (m_q.size() != 0) ? {24'd0, m_q[0]} : 32'd0;
            16'h14: v = m_timer;
            16'h18: v = {{(32-LW){1'b0}}, m_led};
            default: if (o >= 16'h20 && o < 16'h20 + 16'(4*NH)) v = {25'd0, m_hex[(o - 16'h20) / 4]};
        endcase
        return v;
    endfunction

    // One clock cycle: drive, advance the model, then check everything after the edge.
    task automatic cyc(input bit rst, input bit sel, input bit we, input bit re,
                       input logic [15:0] a, input logic [31:0] wd,
                       input bit kv, input logic [7:0] kd, output logic [31:0] rd);
        logic [15:0] o;
        logic [31:0] rv;
        logic [7:0]  dummy;
        logic [7*NH-1:0] eh;
        bit pop, fl, clr, evt;
        o = {a[15:2], 2'b00};
        rst_n = !rst; cpu_sel = sel; cpu_we = we; cpu_re = re;
        cpu_addr = a; cpu_wrdata = wd; kb_valid = kv; kb_data = kd;
        if (rst) begin
            m_q.delete(); m_ovf = 0; m_scroll = 0; m_cursor = 0; m_timer = 0;
            m_rd = 0; m_led = 0;
            for (int i = 0; i < NH; i++) m_hex[i] = 7'h7F;
        end else begin
            rv = m_read(a);
            if (re) m_rd = (sel && !we) ? rv : 32'd0;
            pop = sel && re && !we && o == 16'h0C && m_q.size() > 0;
            fl  = sel && we && o == 16'h10 && wd[0];
            clr = sel && we && o == 16'h10 && wd[1];
            evt = 0;
            if (fl) m_q.delete();
            else begin
                if (pop) dummy = m_q.pop_front();
                if (kv) begin
                    if (m_q.size() < KD) m_q.push_back(kd);
                    else evt = 1;
                end
            end
            if (evt) m_ovf = 1;
            else if (clr) m_ovf = 0;
            m_timer = (sel && we && o == 16'h14) ? wd : m_timer + 32'd1;
            if (sel && we) begin
                case (o)
                    16'h00: m_scroll = wd;
                    16'h04: m_cursor = wd;
                    16'h18: m_led = wd[LW-1:0];
                    default: if (o >= 16'h20 && o < 16'h20 + 16'(4*NH)) m_hex[(o - 16'h20) / 4] = wd[6:0];
                endcase
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1; cpu_sel = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0; kb_valid = 1'b0;
        rd = cpu_rddata;
        for (int i = 0; i < NH; i++) eh[7*i +: 7] = m_hex[i];
        chk("rddata", cpu_rddata, m_rd);
        chk("scroll", vga_extra_line_cnt, m_scroll);
        chk("cursor", {vga_cursor_y, vga_cursor_x}, m_cursor);
        chk("ledr", ledr, m_led);
        chk("hex", hex, eh);
    endtask

    task automatic rd_(input logic [15:0] a, output logic [31:0] d);
        cyc(0, 1, 0, 1, a, 0, 0, 0, d);
    endtask
    task automatic wr_(input logic [15:0] a, input logic [31:0] v);
        logic [31:0] d;
        cyc(0, 1, 1, 0, a, v, 0, 0, d);
    endtask
    task automatic push_(input logic [7:0] v);
        logic [31:0] d;
        cyc(0, 0, 0, 0, 0, 0, 1, v, d);
    endtask
    task automatic idle_();
        logic [31:0] d;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, d);
    endtask

    initial begin
        logic [31:0] r;
        logic [15:0] offs[16];
        offs = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h10, 16'h14, 16'h18, 16'h1C,
                 16'h20, 16'h24, 16'h28, 16'h2C, 16'h30, 16'h34, 16'h38, 16'h40};

        cyc(1, 0, 0, 0, 0, 0, 0, 0, r);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, r);
        chk("rst_rddata", r, 32'd0);

        rd_(16'h00, r); chk("rst_scroll", r, 32'd0);
        rd_(16'h04, r); chk("rst_cursor", r, 32'd0);
        rd_(16'h08, r); chk("rst_status", r, 32'd0);
        rd_(16'h0C, r); chk("rst_kbdata", r, 32'd0);
        rd_(16'h18, r); chk("rst_ledr", r, 32'd0);
        for (int i = 0; i < NH; i++) begin
            rd_(16'(16'h20 + 4*i), r); chk("rst_hex", r, 32'h7F);
        end
        rd_(16'h40, r); chk("unmapped", r, 32'd0);

        wr_(16'h04, 32'h0012_0034);
        chk("cur_y", vga_cursor_y, 16'h0012);
        chk("cur_x", vga_cursor_x, 16'h0034);
        rd_(16'h04, r); chk("cur_rb", r, 32'h0012_0034);

        push_(8'h1C); push_(8'h32); push_(8'h21);
        rd_(16'h08, r); chk("cnt3", r[15:8], 3);
        rd_(16'h0C, r); chk("kb0", r, 32'h1C);
        rd_(16'h08, r); chk("cnt2", r[15:8], 2);
        rd_(16'h0C, r); chk("kb1", r, 32'h32);
        rd_(16'h08, r); chk("cnt1", r[15:8], 1);
        rd_(16'h0C, r); chk("kb2", r, 32'h21);
        rd_(16'h08, r); chk("cnt0", r[15:8], 0);
        rd_(16'h0C, r); chk("kb_empty", r, 32'd0);

        for (int i = 0; i < 17; i++) push_(8'(8'h40 + i));
        rd_(16'h08, r); chk("full_status", r, 32'h0000_1007);
        cyc(0, 1, 0, 1, 16'h0C, 0, 1, 8'h99, r); chk("pp_head", r, 32'h40);
        rd_(16'h08, r); chk("pp_status", r, 32'h0000_1007);
        for (int i = 1; i < 16; i++) begin
            rd_(16'h0C, r); chk("drain", r, 32'(8'h40 + i));
        end
        rd_(16'h0C, r); chk("drain_last", r, 32'h99);
        wr_(16'h10, 32'h2);
        rd_(16'h08, r); chk("ovf_clr", r, 32'd0);

        wr_(16'h14, 32'hFFFF_FFFE);
        idle_();
        rd_(16'h14, r); chk("tmr_ff", r, 32'hFFFF_FFFF);
        rd_(16'h14, r); chk("tmr_wrap", r, 32'h0);
        rd_(16'h14, r); chk("tmr_inc", r, 32'h1);

        for (int i = 0; i < 5; i++) push_(8'(i + 1));
        wr_(16'h28, 32'h40);
        wr_(16'h18, 32'h3FF);
        rd_(16'h08, r); chk("pre_rst_cnt", r[15:8], 5);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, r);
        chk("mr_rddata", r, 32'd0);
        chk("mr_ledr", ledr, 0);
        rd_(16'h08, r); chk("mr_cnt", r, 32'd0);
        rd_(16'h28, r); chk("mr_hex2", r, 32'h7F);

        for (int n = 0; n < 800; n++) begin
            int k;
            bit sel, kv;
            logic [15:0] a;
            logic [31:0] wd;
            k   = $urandom_range(0, 9);
            a   = offs[$urandom_range(0, 15)] | 16'($urandom_range(0, 3));
            sel = ($urandom_range(0, 7) != 0);
            kv  = ($urandom_range(0, 2) == 0);
            wd  = $urandom;
            if (a[15:2] == 14'h4 && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
            if (k < 4)       cyc(0, sel, 0, 1, a, wd, kv, 8'($urandom), r);
            else if (k < 7)  cyc(0, sel, 1, 0, a, wd, kv, 8'($urandom), r);
            else if (k == 7) cyc(0, sel, 1, 1, a, wd, kv, 8'($urandom), r);
            else             cyc(0, 0, 0, 0, a, wd, kv, 8'($urandom), r);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/mmio_periph.md
# mmio_periph

Parametrised memory-mapped peripheral register block that replaces the fixed VGA-info, keyboard-info and 7-segment/LED register modules behind the CPU data port. It holds the VGA scroll/cursor registers, a configurable number of 7-segment and LED outputs, a free-running cycle timer, and a keyboard scancode FIFO with pop-on-read, replacing the old single overwrite register. The parent address map decodes the region prefix and drives `cpu_sel`; this block decodes the 16-bit offset within the region.

## Interface
- `NUM_HEX`, default 6: number of 7-segment outputs, 1..8.
- `LED_W`, default 10: LEDR width, 1..32.
- `KB_DEPTH`, default 16: keyboard FIFO depth; power of two, at least 2.
- `KB_W`, default 8: keyboard data width, at most 16.

- `clk`  in  1: the single clock; everything is rising-edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `cpu_sel`  in  1: the CPU address falls in this block's region.
- `cpu_addr`  in  16: byte offset within the region; bits [1:0] are ignored.
- `cpu_we`  in  1: write strobe; full-word write.
- `cpu_re`  in  1: read strobe.
- `cpu_wrdata`  in  32: write data.
- `cpu_rddata`  out  32: registered read data.
- `kb_valid`  in  1: keyboard push strobe.
- `kb_data`  in  KB_W: scancode.
- `vga_extra_line_cnt`  out  32: scroll register.
- `vga_cursor_x`, `vga_cursor_y`  out  16 each: cursor position.
- `hex`  out  7*NUM_HEX: 7-segment patterns, active-low; digit i is at [7i+6:7i].
- `ledr`  out  LED_W: LED outputs.

## Operation
- An access takes effect only when `cpu_sel` is high. Writes to unmapped or read-only offsets are ignored. Reads from unmapped offsets return 0.
- Register map (byte offsets):
  - 0x00 SCROLL, read/write, 32 bits.
  - 0x04 CURSOR, read/write: {y[31:16], x[15:0]}.
  - 0x08 KB_STATUS, read-only: [0] not-empty, [1] full, [2] overflow (sticky), [15:8] count.
  - 0x0C KB_DATA: a read returns the FIFO head zero-extended and pops it. A read while empty returns 0 and does not pop.
  - 0x10 KB_CTRL, write-only: bit0 flushes the FIFO; bit1 clears overflow.
  - 0x14 TIMER: a 32-bit cycle counter that increments every cycle and wraps at 2^32. A write loads it, and it increments from the loaded value on the next cycle.
  - 0x18 LEDR, read/write: bits [LED_W-1:0]; upper bits read as 0.
  - 0x20+4i HEX[i], read/write for i < NUM_HEX: bits [6:0]. Offsets at or beyond NUM_HEX are unmapped.
- Keyboard FIFO behaviour:
  - A push while not full enqueues the scancode.
  - A push while full is dropped and sets overflow.
  - A push and a pop in the same cycle both take effect and the count is unchanged. This applies when full (no overflow) as well as in the general case. When the FIFO is empty, the pop yields 0 and the push is enqueued.
  - Flush has priority over a same-cycle push and pop: the count becomes 0 and the push is lost.
  - An overflow event in the same cycle as an overflow clear leaves overflow set.
- Asserting `cpu_we` and `cpu_re` together is illegal; the write is performed and the read returns 0.

## Timing
- Read latency is 1 cycle. `cpu_rddata` is valid on the cycle after the `cpu_re` edge. It holds that value until the next accepted read, and goes to 0 after a read that is not selected.
- A pop takes effect on the same edge that registers the data.
- A write is visible on outputs and on readback on the cycle after the `cpu_we` edge.
- A push is visible in KB_STATUS to a read issued on the cycle after `kb_valid`.
- Reset values:
  - `cpu_rddata` = 0, SCROLL = 0, CURSOR = 0, TIMER = 0, `ledr` = 0.
  - Every `hex` digit = 7'h7F (blank).
  - FIFO empty, overflow = 0.
- Reset asserted mid-operation discards FIFO contents and any pending read result on that edge.

## Structure
- The package `mmio_periph_pkg` holds:
  - register offset constants;
  - KB_STATUS bit positions;
  - `HEX_BLANK` = 7'h7F.
- The sub-module `kb_fifo` (parameters KB_DEPTH and KB_W) holds:
  - circular buffer with log2(KB_DEPTH)-bit read/write pointers that wrap;
  - (log2(KB_DEPTH)+1)-bit count;
  - push, pop and flush inputs;
  - head, empty, full and count outputs.
- Overflow logic sits in the top level.

## Test plan
- Reset, then read every mapped offset: all 0 except HEX[i] = 0x7F; unmapped offset 0x40 reads 0.
- Write 0x0012_0034 to CURSOR: `vga_cursor_y` = 0x12 and `vga_cursor_x` = 0x34 on the next cycle; readback returns 0x0012_0034.
- Push 0x1C, 0x32, 0x21, then read KB_DATA three times: returns 0x1C, 0x32, 0x21; status count goes 3, 2, 1, 0; a fourth read returns 0.
- Push 17 scancodes with the default depth: full = 1, overflow = 1, count = 16, and the 17th value is absent. A simultaneous push and pop while full leaves count = 16 with overflow unchanged.
- Write 0xFFFF_FFFE to TIMER: reads on the following cycles return 0xFFFF_FFFF, then 0x0000_0000 (wrap), then increase monotonically.
- Assert `rst_n` low for one cycle while the FIFO holds 5 entries and HEX[2] = 0x40: afterwards count = 0, HEX[2] = 0x7F, `ledr` = 0.
